periph_bus_arbiter: RTL and testbench
=====================================

// Module: periph_bus_arbiter
// PURPOSE
//  Shares the single peripheral bus (timer/LED/switch/digit/UART register map at 0x4000_0000) among
//  NUM_MASTERS requesters, e.g. CPU data port and a UART-to-memory DMA engine. Runs round-robin
//  arbitration with an optional per-master lock for read-modify-write, registers read data, and
//  acknowledges each requester. Sits between the masters and the Peripheral slave port.
// PARAMETERS
//  NUM_MASTERS  2      number of requesters, 2..4
//  LOCK_MAX     255    idle cycles a locked owner may hold the bus before forced release
// PORTS
//  clk        in   1     system clock; all state on posedge
//  reset      in   1     asynchronous, active-high; one clock, reset active-high asynchronous
//  m_req      in   N     per-master request; held with command stable until m_ack
//  m_rd       in   N     per-master read strobe (qualified by m_req)
//  m_wr       in   N     per-master write strobe (qualified by m_req)
//  m_lock     in   N     keep ownership after this transfer
//  m_addr     in   32N   flattened addresses, master i at [32i+31:32i]
//  m_wdata    in   32N   flattened write data
//  m_ack      out  N     one-cycle completion pulse to the owning master
//  m_rdata    out  32    registered read data, valid with m_ack
//  s_rd,s_wr  out  1     slave strobes
//  s_addr     out  32    slave address
//  s_wdata    out  32    slave write data
//  s_rdata    in   32    slave read data, combinational from s_rd/s_addr
//  busy       out  1     high in ACCESS or DONE
//  lock_err   out  1     one-cycle pulse on forced lock release
// BEHAVIOUR
//  Reset: state=IDLE; m_ack=0; m_rdata=0; s_rd=s_wr=0; s_addr=s_wdata=0; busy=0; lock_err=0;
//   rr_ptr=NUM_MASTERS-1, so master 0 wins first; lock_valid=0; lock_cnt=0. Reset mid-transfer aborts
//   it with no m_ack; a partial slave write is not re-issued.
//  FSM IDLE -> ACCESS -> DONE -> IDLE; 3 cycles per transfer, req sampled only in IDLE.
//  IDLE: eligible = lock_valid ? (m_req & onehot(lock_owner)) : m_req. If nonzero, pick first set bit
//   after rr_ptr (wrapping), latch gnt_idx, rr_ptr<=gnt_idx, go ACCESS. If zero, stay IDLE.
//  ACCESS: s_* driven from master gnt_idx. m_wr has priority, so s_rd=m_rd&~m_wr. If neither strobe,
//   null transfer: no slave strobe, still acked. On the read edge m_rdata<=s_rdata; otherwise
//   m_rdata holds.
//  DONE: m_ack[gnt_idx]=1 for exactly this cycle; s_rd=s_wr=0.
//   lock_valid<=m_lock[gnt_idx]; lock_owner<=gnt_idx; lock_cnt<=0. A master holding req high
//   past DONE starts a new arbitration in the following IDLE (back-to-back).
//  Lock timer: in IDLE with lock_valid and owner req low, lock_cnt++. At lock_cnt==LOCK_MAX:
//   lock_valid<=0, lock_err pulses 1 cycle, and the other masters compete that same IDLE cycle.
//  Simultaneous requests: round-robin only, no fixed priority; a new req arriving during
//   ACCESS/DONE waits for IDLE.
//  Width rules: gnt_idx, rr_ptr, lock_owner are $clog2(NUM_MASTERS) bits. lock_cnt is 8 bits
//   and saturates.
//  m_ack and m_rdata outputs are registered. s_* outputs are registered from the latched grant.
// STRUCTURE
//  Shared package periph_bus_pkg: state encodings ARB_IDLE/ARB_ACCESS/ARB_DONE, PERIPH_BASE
//   32'h4000_0000, register offsets TH/TL/TCON/LED/SW/DIGI/UTXD/URXD/UCON.
//  Sub-module arb_rr_pick (combinational): eligible vector + rr_ptr -> found, index.
// TESTING
//  1. reset; m0 req wr 0x4000000C=0xA5 -> s_wr high 1 cycle at t+1, m_ack[0] at t+2, LED=0xA5.
//  2. m0,m1 req reads together each held 3 transfers -> grant order 0,1,0,1,0,1; every gap 3 cycles.
//  3. m1 read 0x40000010, switch=0x3C -> m_rdata=0x0000003C with m_ack[1]; unchanged afterwards.
//  4. m0 lock read TCON, m1 requesting -> m0 write TCON wins next despite rr; unlock frees m1.
//  5. m0 locks then idles, LOCK_MAX=4, m1 req -> lock_err pulse after 4 idle cycles; m1 granted.
//  6. reset during ACCESS of m1 write -> no m_ack; next grant goes to m0; m_rd=m_wr=1 -> write only.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// rtl/periph_bus_pkg.sv - arbiter state encodings and peripheral register map
package periph_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  localparam logic [31:0] OFS_TH   = 32'h0000_0000;
  localparam logic [31:0] OFS_TL   = 32'h0000_0004;
  localparam logic [31:0] OFS_TCON = 32'h0000_0008;
  localparam logic [31:0] OFS_LED  = 32'h0000_000C;
  localparam logic [31:0] OFS_SW   = 32'h0000_0010;
  localparam logic [31:0] OFS_DIGI = 32'h0000_0014;
  localparam logic [31:0] OFS_UTXD = 32'h0000_0018;
  localparam logic [31:0] OFS_URXD = 32'h0000_001C;
  localparam logic [31:0] OFS_UCON = 32'h0000_0020;

endpackage

// File: rtl/periph_bus_arbiter_if.sv
// rtl/periph_bus_arbiter_if.sv - requester and slave-side signals of the peripheral bus arbiter
interface periph_bus_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_rd;
  logic [N-1:0]    m_wr;
  logic [N-1:0]    m_lock;
  logic [32*N-1:0] m_addr;
  logic [32*N-1:0] m_wdata;
  logic [N-1:0]    m_ack;
  logic [31:0]     m_rdata;
  logic            s_rd;
  logic            s_wr;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata;
  logic            busy;
  logic            lock_err;

  modport slave (
    input  m_req, m_rd, m_wr, m_lock, m_addr, m_wdata, s_rdata,
    output m_ack, m_rdata, s_rd, s_wr, s_addr, s_wdata, busy, lock_err
  );

  modport master (
    output m_req, m_rd, m_wr, m_lock, m_addr, m_wdata, s_rdata,
    input  m_ack, m_rdata, s_rd, s_wr, s_addr, s_wdata, busy, lock_err
  );
endinterface

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - first eligible requester after the round-robin pointer, wrapping
module arb_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic         found_o,
  output logic [W-1:0] index_o
);

  always_comb begin
    logic [W:0] cand;
    found_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, rr_ptr_i} + (W+1)'(k);
      if (cand >= (W+1)'(N)) begin
        cand = cand - (W+1)'(N);
      end
      if (!found_o && eligible_i[cand[W-1:0]]) begin
        found_o = 1'b1;
        index_o = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// rtl/periph_bus_arbiter.sv - round-robin arbiter with lock sharing the peripheral slave port
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int LOCK_MAX    = 255
) (
  input logic                 clk,
  input logic                 reset,
  periph_bus_arbiter_if.slave bus
);

  localparam int         W          = $clog2(NUM_MASTERS);
  localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

  arb_state_e             state_q;
  logic [W-1:0]           gnt_idx_q;
  logic [W-1:0]           rr_ptr_q;
  logic [W-1:0]           lock_owner_q;
  logic                   lock_valid_q;
  logic [7:0]             lock_cnt_q;
  logic [7:0]             lock_cnt_d;
  logic [NUM_MASTERS-1:0] m_ack_q;
  logic [31:0]            m_rdata_q;
  logic                   s_rd_q;
  logic                   s_wr_q;
  logic [31:0]            s_addr_q;
  logic [31:0]            s_wdata_q;
  logic                   busy_q;
  logic                   lock_err_q;

  logic [31:0] addr_a  [NUM_MASTERS];
  logic [31:0] wdata_a [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = bus.m_addr[32*i +: 32];
    assign wdata_a[i] = bus.m_wdata[32*i +: 32];
  end

  logic [NUM_MASTERS-1:0] owner_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   lock_idle;
  logic                   lock_expire;
  logic                   pick_found;
  logic [W-1:0]           pick_idx;

  // An expiring lock opens arbitration to everyone in the same IDLE cycle.
  always_comb begin
    owner_mask               = '0;
    owner_mask[lock_owner_q] = 1'b1;
    lock_idle   = lock_valid_q && !bus.m_req[lock_owner_q];
    lock_expire = lock_idle && (lock_cnt_q == LOCK_LIMIT);
    eligible    = (lock_valid_q && !lock_expire) ? (bus.m_req & owner_mask) : bus.m_req;
    lock_cnt_d  = (lock_cnt_q == 8'hFF) ? lock_cnt_q : lock_cnt_q + 8'd1;
  end

  arb_rr_pick #(
    .N (NUM_MASTERS),
    .W (W)
  ) u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .found_o    (pick_found),
    .index_o    (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      gnt_idx_q    <= '0;
      rr_ptr_q     <= W'(NUM_MASTERS - 1);
      lock_owner_q <= '0;
      lock_valid_q <= 1'b0;
      lock_cnt_q   <= '0;
      m_ack_q      <= '0;
      m_rdata_q    <= '0;
      s_rd_q       <= 1'b0;
      s_wr_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      busy_q       <= 1'b0;
      lock_err_q   <= 1'b0;
    end else begin
      m_ack_q    <= '0;
      lock_err_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (lock_expire) begin
            lock_valid_q <= 1'b0;
            lock_err_q   <= 1'b1;
          end else if (lock_idle) begin
            lock_cnt_q <= lock_cnt_d;
          end
          if (pick_found) begin
            gnt_idx_q <= pick_idx;
            rr_ptr_q  <= pick_idx;
            s_wr_q    <= bus.m_wr[pick_idx];
            s_rd_q    <= bus.m_rd[pick_idx] & ~bus.m_wr[pick_idx];
            s_addr_q  <= addr_a[pick_idx];
            s_wdata_q <= wdata_a[pick_idx];
            busy_q    <= 1'b1;
            state_q   <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (s_rd_q) begin
            m_rdata_q <= bus.s_rdata;
          end
          s_rd_q             <= 1'b0;
          s_wr_q             <= 1'b0;
          m_ack_q[gnt_idx_q] <= 1'b1;
          state_q            <= ARB_DONE;
        end
        ARB_DONE: begin
          lock_valid_q <= bus.m_lock[gnt_idx_q];
          lock_owner_q <= gnt_idx_q;
          lock_cnt_q   <= '0;
          busy_q       <= 1'b0;
          state_q      <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.m_ack    = m_ack_q;
  assign bus.m_rdata  = m_rdata_q;
  assign bus.s_rd     = s_rd_q;
  assign bus.s_wr     = s_wr_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.busy     = busy_q;
  assign bus.lock_err = lock_err_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb/tb_periph_bus_arbiter.sv - scoreboard bench for periph_bus_arbiter
module tb_periph_bus_arbiter;
  import periph_bus_pkg::*;

  localparam int NM   = 2;
  localparam int LMAX = 4;

  localparam logic [31:0] TH_VAL   = 32'h0000_1111;
  localparam logic [31:0] TCON_VAL = 32'h0000_0002;
  localparam logic [31:0] SW_VAL   = 32'h0000_003C;
  localparam logic [31:0] DIGI_VAL = 32'h0000_5555;
  localparam logic [31:0] URXD_VAL = 32'h0000_0042;

  typedef struct {
    int          m;
    bit          chk_rd;
    logic [31:0] rdata;
    int          gap;
  } exp_t;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic slv_init = 1'b1;
  always #5 clk = ~clk;

  periph_bus_arbiter_if #(.N(NM)) bus ();

  periph_bus_arbiter #(
    .NUM_MASTERS (NM),
    .LOCK_MAX    (LMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int last_ack = 0;
  int lerr_cnt = 0;
  int lerr_cyc = 0;
  int ack_cnt [NM] = '{default: 0};
  int target  [NM] = '{default: 0};
  exp_t sb[$];
  logic [NM-1:0] req;
  logic [31:0]   regs [0:8];

  function automatic int ridx(input logic [31:0] a);
    return int'((a - PERIPH_BASE) >> 2);
  endfunction

  always_comb begin
    req = '0;
    for (int i = 0; i < NM; i++) req[i] = (ack_cnt[i] < target[i]);
  end
  assign bus.m_req = req;

  // Peripheral register file standing in for the slave port.
  always_comb begin
    bus.s_rdata = 32'hDEAD_BEEF;
    if (bus.s_rd && ridx(bus.s_addr) < 9) bus.s_rdata = regs[ridx(bus.s_addr)];
  end

  always @(posedge clk) begin
    if (slv_init) begin
      for (int i = 0; i < 9; i++) regs[i] <= '0;
      regs[ridx(PERIPH_BASE + OFS_TH)]   <= TH_VAL;
      regs[ridx(PERIPH_BASE + OFS_TCON)] <= TCON_VAL;
      regs[ridx(PERIPH_BASE + OFS_SW)]   <= SW_VAL;
      regs[ridx(PERIPH_BASE + OFS_DIGI)] <= DIGI_VAL;
      regs[ridx(PERIPH_BASE + OFS_URXD)] <= URXD_VAL;
    end else if (bus.s_wr && ridx(bus.s_addr) < 9) begin
      regs[ridx(bus.s_addr)] <= bus.s_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int m, input bit c, input logic [31:0] d, input int g);
    exp_t e;
    e.m = m; e.chk_rd = c; e.rdata = d; e.gap = g;
    sb.push_back(e);
  endtask

  task automatic go(input int m, input bit rd, input bit wr, input bit lk,
                    input logic [31:0] a, input logic [31:0] d, input int n);
    bus.m_rd[m]             = rd;
    bus.m_wr[m]             = wr;
    bus.m_lock[m]           = lk;
    bus.m_addr[32*m +: 32]  = a;
    bus.m_wdata[32*m +: 32] = d;
    target[m]               = target[m] + n;
  endtask

  task automatic wait_acks(input int m, input int bound);
    int k = 0;
    while (ack_cnt[m] < target[m] && k < bound) begin
      tick();
      k++;
    end
    check("ack_wait", ack_cnt[m], target[m]);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    logic [2:0] st;
    while ((sb.size() != 0 || bus.busy || req != '0) && k < bound) begin
      tick();
      k++;
    end
    st = {sb.size() != 0, bus.busy, req != '0};
    check("idle_reached", 32'(st), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ack monitor: every completion is matched against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.lock_err) begin
      lerr_cnt++;
      lerr_cyc = cyc;
    end
    for (int i = 0; i < NM; i++) begin
      if (bus.m_ack[i]) begin
        check("ack_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ack_master", i, e.m);
          if (e.chk_rd) check("ack_rdata", bus.m_rdata, e.rdata);
          if (e.gap > 0) check("ack_gap", cyc - last_ack, e.gap);
        end
        last_ack = cyc;
        ack_cnt[i]++;
      end
    end
  end

  initial begin
    int e0;
    int c0;
    bus.m_rd = '0; bus.m_wr = '0; bus.m_lock = '0;
    bus.m_addr = '0; bus.m_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_ack", 32'(bus.m_ack), 32'd0);
    check("rst_m_rdata", bus.m_rdata, 32'd0);
    check("rst_s_rd", 32'(bus.s_rd), 32'd0);
    check("rst_s_wr", 32'(bus.s_wr), 32'd0);
    check("rst_s_addr", bus.s_addr, 32'd0);
    check("rst_s_wdata", bus.s_wdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_lock_err", 32'(bus.lock_err), 32'd0);
    reset = 1'b0;
    slv_init = 1'b0;
    tick();

    // single write to LED: strobe one cycle after grant, ack the cycle after
    push(0, 1'b0, '0, 0);
    go(0, 1'b0, 1'b1, 1'b0, PERIPH_BASE + OFS_LED, 32'hA5, 1);
    @(posedge clk);
    @(negedge clk);
    check("t1_s_wr", 32'(bus.s_wr), 32'd1);
    check("t1_s_rd", 32'(bus.s_rd), 32'd0);
    check("t1_s_addr", bus.s_addr, PERIPH_BASE + OFS_LED);
    check("t1_s_wdata", bus.s_wdata, 32'hA5);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_no_ack_yet", 32'(bus.m_ack), 32'd0);
    @(negedge clk);
    check("t1_s_wr_drop", 32'(bus.s_wr), 32'd0);
    check("t1_ack", 32'(bus.m_ack), 32'd1);
    wait_idle(20);
    check("t1_led", regs[ridx(PERIPH_BASE + OFS_LED)], 32'hA5);

    // both masters read together, three transfers each: strict alternation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(0, 1'b1, TH_VAL, 0);
    push(1, 1'b1, DIGI_VAL, 3);
    push(0, 1'b1, TH_VAL, 3);
    push(1, 1'b1, DIGI_VAL, 3);
    push(0, 1'b1, TH_VAL, 3);
    push(1, 1'b1, DIGI_VAL, 3);
    go(0, 1'b1, 1'b0, 1'b0, PERIPH_BASE + OFS_TH, '0, 3);
    go(1, 1'b1, 1'b0, 1'b0, PERIPH_BASE + OFS_DIGI, '0, 3);
    wait_idle(60);

    // switch read, then a write must leave m_rdata untouched
    push(1, 1'b1, SW_VAL, 0);
    go(1, 1'b1, 1'b0, 1'b0, PERIPH_BASE + OFS_SW, '0, 1);
    wait_idle(20);
    check("t3_rdata_hold", bus.m_rdata, SW_VAL);
    push(0, 1'b0, '0, 0);
    go(0, 1'b0, 1'b1, 1'b0, PERIPH_BASE + OFS_UTXD, 32'h77, 1);
    wait_idle(20);
    check("t3_rdata_after_wr", bus.m_rdata, SW_VAL);
    check("t3_utxd", regs[ridx(PERIPH_BASE + OFS_UTXD)], 32'h77);

    // locked read-modify-write keeps m1 out until unlock
    push(0, 1'b1, TCON_VAL, 0);
    go(0, 1'b1, 1'b0, 1'b1, PERIPH_BASE + OFS_TCON, '0, 1);
    tick();
    go(1, 1'b1, 1'b0, 1'b0, PERIPH_BASE + OFS_URXD, '0, 1);
    wait_acks(0, 20);
    push(0, 1'b0, '0, 3);
    push(1, 1'b1, URXD_VAL, 3);
    go(0, 1'b0, 1'b1, 1'b0, PERIPH_BASE + OFS_TCON, 32'h3, 1);
    wait_idle(30);
    check("t4_tcon", regs[ridx(PERIPH_BASE + OFS_TCON)], 32'h3);

    // idle lock owner is forced off after LOCK_MAX counted cycles
    push(0, 1'b1, TH_VAL, 0);
    go(0, 1'b1, 1'b0, 1'b1, PERIPH_BASE + OFS_TH, '0, 1);
    wait_acks(0, 20);
    e0 = lerr_cnt;
    c0 = cyc;
    push(1, 1'b1, DIGI_VAL, LMAX + 3);
    go(1, 1'b1, 1'b0, 1'b0, PERIPH_BASE + OFS_DIGI, '0, 1);
    wait_acks(1, 30);
    check("t5_lock_err_count", lerr_cnt - e0, 32'd1);
    check("t5_lock_err_cycle", lerr_cyc - c0, LMAX + 1);
    wait_idle(20);

    // reset mid-ACCESS drops the transfer; write wins over read afterwards
    go(1, 1'b0, 1'b1, 1'b0, PERIPH_BASE + OFS_UCON, 32'h99, 1);
    tick();
    check("t6_s_wr_before_rst", 32'(bus.s_wr), 32'd1);
    reset = 1'b1;
    target[1] = ack_cnt[1];
    #1;
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_s_wr", 32'(bus.s_wr), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    check("t6_ucon_untouched", regs[ridx(PERIPH_BASE + OFS_UCON)], 32'd0);
    push(0, 1'b0, '0, 0);
    push(1, 1'b1, 32'h5A, 3);
    go(0, 1'b1, 1'b1, 1'b0, PERIPH_BASE + OFS_UCON, 32'h5A, 1);
    go(1, 1'b1, 1'b0, 1'b0, PERIPH_BASE + OFS_UCON, '0, 1);
    @(posedge clk);
    @(negedge clk);
    check("t6_s_wr", 32'(bus.s_wr), 32'd1);
    check("t6_s_rd", 32'(bus.s_rd), 32'd0);
    check("t6_s_addr", bus.s_addr, PERIPH_BASE + OFS_UCON);
    wait_idle(30);
    check("t6_ucon", regs[ridx(PERIPH_BASE + OFS_UCON)], 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
